// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock controller.
// Holds the FSM state encoding, the divider code width and the parameter defaults.
package pll_ctrl_pkg;

   localparam int CODE_W = 6;

   localparam int DEF_RST_HOLD     = 32;
   localparam int DEF_LOCK_TIMEOUT = 270000;
   localparam int DEF_STABLE_CNT   = 1024;
   localparam int DEF_MAX_RETRY    = 3;

   typedef enum logic [2:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level, cleared by synchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up controller: sequences PLL reset, qualifies lock, retries on timeout
// and hands a downstream reset plus divider codes to the PLL.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int                RST_HOLD     = DEF_RST_HOLD,
   parameter int                LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int                STABLE_CNT   = DEF_STABLE_CNT,
   parameter int                MAX_RETRY    = DEF_MAX_RETRY,
   parameter logic [CODE_W-1:0] INIT_IDSEL   = 6'd0,
   parameter logic [CODE_W-1:0] INIT_FBDSEL  = 6'd0,
   parameter logic [CODE_W-1:0] INIT_ODSEL   = 6'd0
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              pll_lock,
   input  logic              cfg_valid,
   input  logic [CODE_W-1:0] cfg_idsel,
   input  logic [CODE_W-1:0] cfg_fbdsel,
   input  logic [CODE_W-1:0] cfg_odsel,
   output logic              cfg_ready,
   output logic              pll_reset,
   output logic [CODE_W-1:0] pll_idsel,
   output logic [CODE_W-1:0] pll_fbdsel,
   output logic [CODE_W-1:0] pll_odsel,
   output logic              locked,
   output logic              rst_out,
   output logic              fail,
   output logic [7:0]        lock_loss_cnt
);

   localparam int CNT_MAX = max3(RST_HOLD, LOCK_TIMEOUT, STABLE_CNT);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] WAIT_END   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);
   localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(MAX_RETRY - 1);

   logic              lock_s;
   logic              hs_s;
   logic              retry_inc_s;

   pll_state_e        state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [RTY_W-1:0]  retry_q,     retry_d;
   logic [7:0]        loss_q,      loss_d;
   logic [CODE_W-1:0] idsel_q,     idsel_d;
   logic [CODE_W-1:0] fbdsel_q,    fbdsel_d;
   logic [CODE_W-1:0] odsel_q,     odsel_d;
   logic              pll_reset_q, pll_reset_d;
   logic              locked_q,    locked_d;
   logic              rst_out_q,   rst_out_d;
   logic              fail_q,      fail_d;
   logic              cfg_ready_q, cfg_ready_d;

   sync_2ff u_lock_sync (
      .clk   (clkin),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   assign hs_s = cfg_valid & cfg_ready_q;

   always_comb begin
      state_d     = state_q;
      retry_inc_s = 1'b0;
      loss_d      = loss_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_END) state_d = ST_WAIT_LOCK;
            else                   state_d = ST_HOLD;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == WAIT_END) begin
               retry_inc_s = 1'b1;
               state_d     = (retry_q == RTY_LAST) ? ST_FAIL : ST_HOLD;
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_STABLE: begin
            if (!lock_s)                  state_d = ST_WAIT_LOCK;
            else if (cnt_q == STABLE_END) state_d = ST_RUN;
            else                          state_d = ST_STABLE;
         end
         ST_RUN: begin
            // A lock loss is counted even when a new config is accepted in the same cycle.
            if (hs_s || !lock_s) state_d = ST_HOLD;
            else                 state_d = ST_RUN;
            if (!lock_s && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
            else                              loss_d = loss_q;
         end
         ST_FAIL: begin
            if (hs_s) state_d = ST_HOLD;
            else      state_d = ST_FAIL;
         end
         default: state_d = ST_HOLD;
      endcase

      if (hs_s || (state_d == ST_RUN)) retry_d = {RTY_W{1'b0}};
      else if (retry_inc_s)            retry_d = retry_q + RTY_W'(1);
      else                             retry_d = retry_q;

      if (hs_s) begin
         idsel_d  = cfg_idsel;
         fbdsel_d = cfg_fbdsel;
         odsel_d  = cfg_odsel;
      end else begin
         idsel_d  = idsel_q;
         fbdsel_d = fbdsel_q;
         odsel_d  = odsel_q;
      end

      if (state_d != state_q)  cnt_d = {CNT_W{1'b0}};
      else if (cnt_q == CNT_TOP) cnt_d = cnt_q;
      else                       cnt_d = cnt_q + CNT_W'(1);

      // Outputs decode the next state so they register in step with state_q.
      pll_reset_d = (state_d == ST_HOLD) || (state_d == ST_FAIL);
      locked_d    = (state_d == ST_RUN);
      rst_out_d   = (state_d != ST_RUN);
      fail_d      = (state_d == ST_FAIL);
      cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= ST_HOLD;
         cnt_q       <= {CNT_W{1'b0}};
         retry_q     <= {RTY_W{1'b0}};
         loss_q      <= 8'd0;
         idsel_q     <= INIT_IDSEL;
         fbdsel_q    <= INIT_FBDSEL;
         odsel_q     <= INIT_ODSEL;
         pll_reset_q <= 1'b1;
         locked_q    <= 1'b0;
         rst_out_q   <= 1'b1;
         fail_q      <= 1'b0;
         cfg_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         idsel_q     <= idsel_d;
         fbdsel_q    <= fbdsel_d;
         odsel_q     <= odsel_d;
         pll_reset_q <= pll_reset_d;
         locked_q    <= locked_d;
         rst_out_q   <= rst_out_d;
         fail_q      <= fail_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready     = cfg_ready_q;
   assign pll_reset     = pll_reset_q;
   assign pll_idsel     = idsel_q;
   assign pll_fbdsel    = fbdsel_q;
   assign pll_odsel     = odsel_q;
   assign locked        = locked_q;
   assign rst_out       = rst_out_q;
   assign fail          = fail_q;
   assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed bring-up scenarios plus a randomized
// phase, all compared each cycle against a phase-level reference model.
module tb_pll_lock_ctrl;

   localparam int RST_HOLD     = 4;
   localparam int LOCK_TIMEOUT = 16;
   localparam int STABLE_CNT   = 8;
   localparam int MAX_RETRY    = 2;
   localparam logic [5:0] I_ID = 6'h03;
   localparam logic [5:0] I_FB = 6'h11;
   localparam logic [5:0] I_OD = 6'h01;

   localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

   logic       clkin = 1'b0;
   logic       reset, pll_lock, cfg_valid;
   logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
   logic       cfg_ready, pll_reset, locked, rst_out, fail;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic [7:0] lock_loss_cnt;

   int   n_vec = 0;
   int   n_err = 0;
   logic chk_en = 1'b0;

   int         m_phase, m_in, m_tries, m_loss;
   logic       m_s1, m_s2, m_hs;
   logic [5:0] m_id, m_fb, m_od;

   always #5 clkin = ~clkin;

   pll_lock_ctrl #(
      .RST_HOLD(RST_HOLD), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CNT(STABLE_CNT),
      .MAX_RETRY(MAX_RETRY), .INIT_IDSEL(I_ID), .INIT_FBDSEL(I_FB), .INIT_ODSEL(I_OD)
   ) dut (
      .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .cfg_valid(cfg_valid),
      .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
      .cfg_ready(cfg_ready), .pll_reset(pll_reset), .pll_idsel(pll_idsel),
      .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .locked(locked),
      .rst_out(rst_out), .fail(fail), .lock_loss_cnt(lock_loss_cnt)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks which phase the controller is in and how long it has been there.
   always @(posedge clkin) begin : ref_model
      int   nxt, tries, loss;
      logic ls, hs;
      if (reset) begin
         m_phase <= P_HOLD; m_in <= 0; m_tries <= 0; m_loss <= 0;
         m_s1 <= 1'b0; m_s2 <= 1'b0; m_hs <= 1'b0;
         m_id <= I_ID; m_fb <= I_FB; m_od <= I_OD;
      end else begin
         ls    = m_s2;
         hs    = cfg_valid && (m_phase == P_RUN || m_phase == P_FAIL);
         nxt   = m_phase;
         tries = m_tries;
         loss  = m_loss;
         case (m_phase)
            P_HOLD:   if (m_in + 1 == RST_HOLD) nxt = P_WAIT;
            P_WAIT:   if (ls) nxt = P_STABLE;
                      else if (m_in + 1 == LOCK_TIMEOUT) begin
                         tries = tries + 1;
                         nxt   = (tries == MAX_RETRY) ? P_FAIL : P_HOLD;
                      end
            P_STABLE: if (!ls) nxt = P_WAIT;
                      else if (m_in + 1 == STABLE_CNT) nxt = P_RUN;
            P_RUN: begin
               if (!ls) begin
                  nxt  = P_HOLD;
                  loss = (loss < 255) ? loss + 1 : 255;
               end
               if (hs) nxt = P_HOLD;
            end
            default:  if (hs) nxt = P_HOLD;
         endcase
         if (hs || nxt == P_RUN) tries = 0;
         if (hs) begin
            m_id <= cfg_idsel; m_fb <= cfg_fbdsel; m_od <= cfg_odsel;
         end
         m_s1    <= pll_lock;
         m_s2    <= m_s1;
         m_in    <= (nxt == m_phase) ? m_in + 1 : 0;
         m_phase <= nxt;
         m_tries <= tries;
         m_loss  <= loss;
         m_hs    <= hs;
      end
   end

   // Every cycle, away from the active edge, compare all outputs with the model.
   always @(negedge clkin) begin
      if (chk_en) begin
         chk_eq("pll_reset", pll_reset, (m_phase == P_HOLD) || (m_phase == P_FAIL));
         chk_eq("locked",    locked,    m_phase == P_RUN);
         chk_eq("rst_out",   rst_out,   m_phase != P_RUN);
         chk_eq("fail",      fail,      m_phase == P_FAIL);
         chk_eq("cfg_ready", cfg_ready, (m_phase == P_RUN) || (m_phase == P_FAIL));
         chk_eq("idsel",     pll_idsel,  m_id);
         chk_eq("fbdsel",    pll_fbdsel, m_fb);
         chk_eq("odsel",     pll_odsel,  m_od);
         chk_eq("loss_cnt",  lock_loss_cnt, m_loss);
      end
   end

   task automatic tick();
      @(negedge clkin);
   endtask

   task automatic do_reset();
      reset = 1'b1; cfg_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic wait_locked(input logic lvl, input int budget, input string tag);
      int n = 0;
      while (locked !== lvl && n < budget) begin tick(); n++; end
      chk_eq(tag, locked, lvl);
   endtask

   task automatic cycles_until_fail(input string tag);
      int n = 0;
      while (fail !== 1'b1 && n < 100) begin tick(); n++; end
      chk_eq(tag, n, 2 * (RST_HOLD + LOCK_TIMEOUT));
   endtask

   initial begin
      int n, prev, seg, rst_fall;
      logic lvl;
      reset = 1'b1; pll_lock = 1'b0; cfg_valid = 1'b0;
      cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
      tick(); tick();
      chk_en = 1'b1;
      chk_eq("rst_pll_reset", pll_reset, 1'b1);
      chk_eq("rst_locked", locked, 1'b0);
      chk_eq("rst_idsel", pll_idsel, I_ID);

      // Normal start: lock applied two cycles after reset release.
      reset = 1'b0; n = 0; rst_fall = -1;
      while (locked !== 1'b1 && n < 60) begin
         tick(); n++;
         if (n == 2) pll_lock = 1'b1;
         if (rst_fall < 0 && pll_reset == 1'b0) rst_fall = n;
      end
      chk_eq("pll_reset_fall", rst_fall, RST_HOLD);
      chk_eq("lock_latency", n, RST_HOLD + 1 + STABLE_CNT);
      chk_eq("start_rst_out", rst_out, 1'b0);

      // Lock loss in RUN, then a one-cycle glitch while qualifying.
      pll_lock = 1'b0; tick(); pll_lock = 1'b1;
      wait_locked(1'b0, 10, "loss_drop");
      chk_eq("loss_one", lock_loss_cnt, 8'd1);
      chk_eq("loss_rst_out", rst_out, 1'b1);
      n = 0;
      while (m_phase != P_STABLE && n < 40) begin tick(); n++; end
      tick(); tick();
      pll_lock = 1'b0; tick(); pll_lock = 1'b1;
      wait_locked(1'b1, 60, "glitch_relock");

      // Config accepted in the same cycle the synchronized lock falls.
      prev = m_loss;
      pll_lock = 1'b0; tick(); tick();
      cfg_valid = 1'b1; cfg_idsel = 6'h08; cfg_fbdsel = 6'h27; cfg_odsel = 6'h08;
      tick();
      cfg_valid = 1'b0; pll_lock = 1'b1;
      chk_eq("sim_idsel", pll_idsel, 6'h08);
      chk_eq("sim_fbdsel", pll_fbdsel, 6'h27);
      chk_eq("sim_loss", lock_loss_cnt, prev + 1);
      n = 0;
      while (pll_reset !== 1'b0 && n < 20) begin tick(); n++; end
      chk_eq("sim_single_hold", n, RST_HOLD);

      // Repeated lock loss saturates the counter.
      for (int k = 0; k < 300; k++) begin
         wait_locked(1'b1, 60, "rep_lock");
         pll_lock = 1'b0; tick(); pll_lock = 1'b1;
         wait_locked(1'b0, 10, "rep_drop");
      end
      chk_eq("loss_sat", lock_loss_cnt, 8'd255);

      // No lock at all: two full rounds, then FAIL until a config arrives.
      pll_lock = 1'b0; do_reset();
      cycles_until_fail("fail_time");
      tick(); tick();
      chk_eq("fail_pll_reset", pll_reset, 1'b1);
      cfg_valid = 1'b1; cfg_idsel = 6'h05; cfg_fbdsel = 6'h1F; cfg_odsel = 6'h02;
      tick();
      cfg_valid = 1'b0;
      chk_eq("cfg_fail_clr", fail, 1'b0);
      chk_eq("cfg_idsel", pll_idsel, 6'h05);
      chk_eq("cfg_fbdsel", pll_fbdsel, 6'h1F);
      chk_eq("cfg_odsel", pll_odsel, 6'h02);

      // Reset during the second WAIT_LOCK round clears the retry count.
      n = 0;
      while (!(m_phase == P_WAIT && m_tries == 1) && n < 80) begin tick(); n++; end
      tick(); tick();
      reset = 1'b1; cfg_valid = 1'b1;
      tick();
      chk_eq("mid_rst_pll_reset", pll_reset, 1'b1);
      chk_eq("mid_rst_rst_out", rst_out, 1'b1);
      chk_eq("mid_rst_fail", fail, 1'b0);
      chk_eq("mid_rst_ready", cfg_ready, 1'b0);
      chk_eq("mid_rst_loss", lock_loss_cnt, 8'd0);
      chk_eq("mid_rst_idsel", pll_idsel, I_ID);
      chk_eq("mid_rst_odsel", pll_odsel, I_OD);
      reset = 1'b0; cfg_valid = 1'b0;
      cycles_until_fail("retry_cleared");

      // Randomized lock behaviour, config offers held until accepted, rare resets.
      seg = 0; lvl = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (seg == 0) begin
            seg = $urandom_range(1, 30);
            lvl = ($urandom_range(0, 3) != 0);
         end
         seg--;
         pll_lock = lvl;
         if (cfg_valid && m_hs) begin
            cfg_valid = 1'b0;
         end else if (!cfg_valid && $urandom_range(0, 39) == 0) begin
            cfg_valid  = 1'b1;
            cfg_idsel  = 6'($urandom);
            cfg_fbdsel = 6'($urandom);
            cfg_odsel  = 6'($urandom);
         end
         reset = ($urandom_range(0, 499) == 0);
         if (reset) cfg_valid = 1'b0;
         tick();
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
